// File: rtl/dram_page_sched_if.sv
// dram_page_sched_if: request/response handshake plus DRAM command/data pins for dram_page_sched.
// Ports: req_* (request, valid/ready), rsp_* (completion pulse), row_open, DRAM_* (command bus and read return).
// slave = scheduler view, master = requester plus DRAM model view.
interface dram_page_sched_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [20:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        row_open;
  logic        DRAM_valid;
  logic [31:0] DRAM_Q;
  logic        DRAM_CSn;
  logic        DRAM_RASn;
  logic        DRAM_CASn;
  logic [3:0]  DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, DRAM_valid, DRAM_Q,
    output req_ready, rsp_valid, rsp_rdata, row_open,
           DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, DRAM_valid, DRAM_Q,
    input  req_ready, rsp_valid, rsp_rdata, row_open,
           DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A, DRAM_D
  );
endinterface

// File: rtl/dram_page_sched.sv
// dram_page_sched: single-bank open-page DRAM scheduler; keeps one row open, issues PRE/ACT/RD/WR with TRP/TRCD spacing.
// Latency: first command the cycle after acceptance; read rsp one cycle after DRAM_valid, write rsp TWR cycles after WR.
// Backpressure: req_ready high only in IDLE, so one request is in flight; optional auto-precharge after IDLE_CLOSE idle cycles.
// Ports: clk, rstn (async active-low), bus (dram_page_sched_if.slave: req_*, rsp_*, row_open, DRAM_*).
module dram_page_sched #(
  parameter int TRP        = 5,
  parameter int TRCD       = 5,
  parameter int TWR        = 5,
  parameter int IDLE_CLOSE = 0
) (
  input  logic             clk,
  input  logic             rstn,
  dram_page_sched_if.slave bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PRE      = 4'd1;
  localparam logic [3:0] S_PRE_WAIT = 4'd2;
  localparam logic [3:0] S_ACT      = 4'd3;
  localparam logic [3:0] S_ACT_WAIT = 4'd4;
  localparam logic [3:0] S_RD       = 4'd5;
  localparam logic [3:0] S_RD_WAIT  = 4'd6;
  localparam logic [3:0] S_WR       = 4'd7;
  localparam logic [3:0] S_WR_WAIT  = 4'd8;

  localparam logic [2:0] C_NONE = 3'd0;
  localparam logic [2:0] C_ACT  = 3'd1;
  localparam logic [2:0] C_PRE  = 3'd2;
  localparam logic [2:0] C_RD   = 3'd3;
  localparam logic [2:0] C_WR   = 3'd4;

  localparam int TMAX = (TRP > TRCD) ? ((TRP > TWR) ? TRP : TWR) : ((TRCD > TWR) ? TRCD : TWR);
  localparam int CW   = $clog2(TMAX + 1);
  // The command cycle itself plus the wait states make up the full spacing,
  // so the wait counter is loaded with (T - 2) and exits when it hits zero.
  localparam logic [CW-1:0] TRP_LD  = CW'(TRP - 2);
  localparam logic [CW-1:0] TRCD_LD = CW'(TRCD - 2);
  localparam logic [CW-1:0] TWR_LD  = CW'(TWR - 2);

  localparam int ICW = (IDLE_CLOSE > 1) ? $clog2(IDLE_CLOSE) : 1;
  localparam logic [ICW-1:0] IC_LAST = ICW'(IDLE_CLOSE - 1);

  logic [3:0]     state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [ICW-1:0] idle_cnt, idle_nxt;
  logic           auto_close, auto_nxt;
  logic [2:0]     issue;
  logic           rsp_fire;

  logic           row_open_q;
  logic [10:0]    open_row;
  logic           wr_q;
  logic [20:2]    addr_q;
  logic [31:0]    wdata_q;
  logic [3:0]     wstrb_q;

  logic           csn_q, rasn_q, casn_q;
  logic [3:0]     wen_q;
  logic [10:0]    a_q;
  logic [31:0]    d_q;
  logic           rsp_valid_q;
  logic [31:0]    rsp_rdata_q;

  logic           in_idle, accept, hit;
  logic           pre_done, act_done, wr_done;
  logic [10:0]    cmd_row;
  logic [7:0]     cmd_col;
  logic           cmd_write;
  logic [31:0]    cmd_wdata;
  logic [3:0]     cmd_wstrb;
  logic           unused_addr_lsb;

  assign in_idle = (state == S_IDLE);
  assign accept  = in_idle && bus.req_valid;
  assign hit     = row_open_q && (bus.req_addr[20:10] == open_row);

  // Commands issued straight out of IDLE use the live request; later ones use the latched copy.
  assign cmd_row   = in_idle ? bus.req_addr[20:10] : addr_q[20:10];
  assign cmd_col   = in_idle ? bus.req_addr[9:2]   : addr_q[9:2];
  assign cmd_write = in_idle ? bus.req_write       : wr_q;
  assign cmd_wdata = in_idle ? bus.req_wdata       : wdata_q;
  assign cmd_wstrb = in_idle ? bus.req_wstrb       : wstrb_q;
  assign unused_addr_lsb = ^bus.req_addr[1:0];

  assign pre_done = ((state == S_PRE) && (TRP <= 1))  || ((state == S_PRE_WAIT) && (cnt == '0));
  assign act_done = ((state == S_ACT) && (TRCD <= 1)) || ((state == S_ACT_WAIT) && (cnt == '0));
  assign wr_done  = ((state == S_WR)  && (TWR <= 1))  || ((state == S_WR_WAIT)  && (cnt == '0));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idle_nxt  = '0;
    auto_nxt  = auto_close;
    issue     = C_NONE;
    rsp_fire  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          // A request beats a same-cycle idle timeout; the idle count clears.
          auto_nxt = 1'b0;
          if (hit) begin
            issue     = bus.req_write ? C_WR : C_RD;
            state_nxt = bus.req_write ? S_WR : S_RD;
          end else if (row_open_q) begin
            issue     = C_PRE;
            state_nxt = S_PRE;
          end else begin
            issue     = C_ACT;
            state_nxt = S_ACT;
          end
        end else if ((IDLE_CLOSE > 0) && row_open_q) begin
          if (idle_cnt == IC_LAST) begin
            issue     = C_PRE;
            state_nxt = S_PRE;
            auto_nxt  = 1'b1;
          end else begin
            idle_nxt = idle_cnt + ICW'(1);
          end
        end
      end
      S_PRE, S_PRE_WAIT: begin
        if (pre_done) begin
          if (auto_close) begin
            state_nxt = S_IDLE;
            auto_nxt  = 1'b0;
          end else begin
            issue     = C_ACT;
            state_nxt = S_ACT;
          end
        end else if (state == S_PRE) begin
          cnt_nxt   = TRP_LD;
          state_nxt = S_PRE_WAIT;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_ACT, S_ACT_WAIT: begin
        if (act_done) begin
          issue     = cmd_write ? C_WR : C_RD;
          state_nxt = cmd_write ? S_WR : S_RD;
        end else if (state == S_ACT) begin
          cnt_nxt   = TRCD_LD;
          state_nxt = S_ACT_WAIT;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_RD: state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        if (bus.DRAM_valid) begin
          rsp_fire  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WR, S_WR_WAIT: begin
        if (wr_done) begin
          rsp_fire  = 1'b1;
          state_nxt = S_IDLE;
        end else if (state == S_WR) begin
          cnt_nxt   = TWR_LD;
          state_nxt = S_WR_WAIT;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idle_cnt    <= '0;
      auto_close  <= 1'b0;
      row_open_q  <= 1'b0;
      open_row    <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      csn_q       <= 1'b1;
      rasn_q      <= 1'b1;
      casn_q      <= 1'b1;
      wen_q       <= 4'hF;
      a_q         <= '0;
      d_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idle_cnt    <= idle_nxt;
      auto_close  <= auto_nxt;
      rsp_valid_q <= rsp_fire;
      if (rsp_fire && (state == S_RD_WAIT)) rsp_rdata_q <= bus.DRAM_Q;
      if (accept) begin
        wr_q    <= bus.req_write;
        addr_q  <= bus.req_addr[20:2];
        wdata_q <= bus.req_wdata;
        wstrb_q <= bus.req_wstrb;
      end
      // NOP by default; A and D keep their last values.
      csn_q  <= 1'b1;
      rasn_q <= 1'b1;
      casn_q <= 1'b1;
      wen_q  <= 4'hF;
      case (issue)
        C_ACT: begin
          csn_q      <= 1'b0;
          rasn_q     <= 1'b0;
          a_q        <= cmd_row;
          row_open_q <= 1'b1;
          open_row   <= cmd_row;
        end
        C_PRE: begin
          csn_q      <= 1'b0;
          rasn_q     <= 1'b0;
          wen_q      <= 4'h0;
          a_q        <= open_row;
          row_open_q <= 1'b0;
        end
        C_RD: begin
          csn_q  <= 1'b0;
          casn_q <= 1'b0;
          a_q    <= {3'b000, cmd_col};
        end
        C_WR: begin
          csn_q  <= 1'b0;
          casn_q <= 1'b0;
          wen_q  <= ~cmd_wstrb;
          a_q    <= {3'b000, cmd_col};
          d_q    <= cmd_wdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = rstn && in_idle;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.row_open  = row_open_q;
  assign bus.DRAM_CSn  = csn_q;
  assign bus.DRAM_RASn = rasn_q;
  assign bus.DRAM_CASn = casn_q;
  assign bus.DRAM_WEn  = wen_q;
  assign bus.DRAM_A    = a_q;
  assign bus.DRAM_D    = d_q;

endmodule
